rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Three-client read arbiter that shares one SDRAM read port between the 68k program-ROM cache and two graphics ROM fetchers. Sits directly downstream of the program cache: it consumes the cache's level-held `rom_req`/`rom_addr` and returns `rom_valid`/`rom_data`. It adds a per-client SDRAM base offset and serialises requests onto a single pulse-request/pulse-ack SDRAM channel.

## Interface
- `AW`, 23: client word-address width.
- `DW`, 16: data width.
- `BASE0`, 24'h000000: SDRAM word base for client 0 (68k program cache).
- `BASE1`, 24'h080000: SDRAM word base for client 1 (tile ROM).
- `BASE2`, 24'h100000: SDRAM word base for client 2 (sprite ROM).

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req[2:0]`  in  3  per-client level request; held high until the client chooses to drop it.
- `addr0`, `addr1`, `addr2`  in  AW each  client word addresses; stable while the matching `req` is high.
- `valid[2:0]`  out  3  one-cycle completion pulse per client.
- `dout`  out  DW  read data; meaningful in the cycle that any `valid` bit is high.
- `sdram_req`  out  1  one-cycle request pulse.
- `sdram_addr`  out  24  SDRAM word address; held from the `sdram_req` cycle until the ack.
- `sdram_ack`  in  1  one-cycle pulse; `sdram_data` is valid in the same cycle.
- `sdram_data`  in  DW  read data.
- `busy`  out  1  high in ISSUE and WAIT.

## Operation
- Reset values: `valid`=0, `dout`=0, `sdram_req`=0, `sdram_addr`=0, `busy`=0. `served[2:0]`=0, state=IDLE, grant pointer=0.
- Pending for client i = `req[i] & ~served[i]`. `served[i]` is set when client i receives `valid[i]`. It is cleared in any cycle where `req[i]`=0. A client that keeps `req` high after completion, as the cache does, is therefore not served twice.
- IDLE: if any request is pending, select a winner and latch its index. Set `sdram_addr` = `BASEi + {1'b0, addri}`. Sum is modulo 2^24 and the carry is dropped. Pulse `sdram_req` and go to ISSUE.
- ISSUE: lasts one cycle. `sdram_req` returns to 0. Go to WAIT. If `sdram_ack` arrives in this cycle, handle it as described for WAIT.
- WAIT: on `sdram_ack`, if `req[winner]` is still 1, then `dout`←`sdram_data`, pulse `valid[winner]`, and set `served[winner]`. If `req[winner]` is 0, the data is discarded, no `valid` pulse is produced, and `served` is left unchanged. In both cases go to IDLE.
- Only one transaction is outstanding at a time. Requests that arrive during ISSUE or WAIT stay pending.
- `sdram_ack` seen in IDLE is ignored. This covers a stale ack after reset.
- Reset asserted mid-transaction aborts immediately. No `valid` is produced for the aborted request.

## Timing
- `req` is sampled high at edge N in IDLE. `sdram_req` is high during cycle N+1 and `busy` rises at N+1.
- `sdram_ack` is sampled at edge M. `valid`/`dout` are high during cycle M+1. State is IDLE at M+1. The next `sdram_req` is at M+2 at the earliest.
- Minimum client latency, request to `valid`: SDRAM ack latency + 2 cycles.
- A simultaneous `req` drop and `sdram_ack` in the same cycle counts as dropped: no `valid` is produced.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin arbitration. The search starts at (last winner + 1) mod 3, and the pointer updates at grant. With all three clients pending continuously, the grant order is 0,1,2,0,…
- Not defined: fixed priority, client 0 > 1 > 2. The grant pointer is not implemented.

## Test plan
- Single request: `req`=3'b001, `addr0`=23'h000123, ack 4 cycles after `sdram_req` with `sdram_data`=16'hBEEF → `sdram_addr`=24'h000123, `valid`=3'b001 for one cycle with `dout`=16'hBEEF. `req` is held high for 5 more cycles and no second `sdram_req` is issued.
- Base offset and wrap: client 2, `BASE2`=24'hFFFFF0, `addr2`=23'h000020 → `sdram_addr`=24'h000010.
- Contention: all three `req` rise in the same cycle. With `ARB_ROUND_ROBIN_EN`, grants are 0,1,2. Without it, grants are 0,1,2 as well. If client 0 re-requests (drop then raise) before the second grant, the macro-off order becomes 0,0,1,2.
- Abandoned request: client 1 drops `req` during WAIT, then ack arrives with 16'h1234 → no `valid`, state returns to IDLE, and the next pending client is served.
- Reset mid-operation: assert `reset` in WAIT, then release and deliver a stale `sdram_ack` → all outputs 0, no `valid`, and no `sdram_req` until a new `req`.

Source files
------------

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - three-client ROM read arbiter onto one pulse req/ack SDRAM port
// Define ARB_ROUND_ROBIN_EN for round-robin grants; otherwise fixed priority 0 > 1 > 2.
module rom_arbiter #(
  parameter int          AW    = 23,
  parameter int          DW    = 16,
  parameter logic [23:0] BASE0 = 24'h000000,
  parameter logic [23:0] BASE1 = 24'h080000,
  parameter logic [23:0] BASE2 = 24'h100000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  output logic [2:0]    valid,
  output logic [DW-1:0] dout,
  output logic          sdram_req,
  output logic [23:0]   sdram_addr,
  input  logic          sdram_ack,
  input  logic [DW-1:0] sdram_data,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      winner_q, winner_d;
  logic [2:0]      served_q, served_d;
  logic [2:0]      valid_q, valid_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            sdram_req_q, sdram_req_d;
  logic [23:0]     sdram_addr_q, sdram_addr_d;

  logic [2:0]      pending;
  logic            grant_found;
  logic [1:0]      grant_idx;
  logic [23:0]     grant_addr;
  logic [2:0]      win_oh;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      cand;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction
`endif

  // Winner selection: scan from the highest-ranked candidate last so it overrides.
  always_comb begin
    pending     = req & ~served_q;
    grant_found = |pending;
    grant_idx   = 2'd0;
`ifdef ARB_ROUND_ROBIN_EN
    cand        = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = wrap3(3'(ptr_q) + 3'(k));
      if (pending[cand]) grant_idx = cand;
    end
`else
    for (int k = 2; k >= 0; k--) begin
      if (pending[k]) grant_idx = 2'(k);
    end
`endif
    case (grant_idx)
      2'd1:    grant_addr = BASE1 + 24'(addr1);
      2'd2:    grant_addr = BASE2 + 24'(addr2);
      default: grant_addr = BASE0 + 24'(addr0);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    served_d     = served_q & req;
    valid_d      = 3'b000;
    dout_d       = dout_q;
    sdram_req_d  = 1'b0;
    sdram_addr_d = sdram_addr_q;
    win_oh       = 3'b001 << winner_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          winner_d     = grant_idx;
          sdram_addr_d = grant_addr;
          sdram_req_d  = 1'b1;
          state_d      = S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d        = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
`endif
        end
      end
      S_ISSUE, S_WAIT: begin
        if (state_q == S_ISSUE) state_d = S_WAIT;
        // A client that dropped req by the ack cycle has abandoned the read.
        if (sdram_ack) begin
          state_d = S_IDLE;
          if (|(req & win_oh)) begin
            dout_d   = sdram_data;
            valid_d  = win_oh;
            served_d = served_d | win_oh;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      winner_q     <= 2'd0;
      served_q     <= 3'b000;
      valid_q      <= 3'b000;
      dout_q       <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= 24'd0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q        <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      served_q     <= served_d;
      valid_q      <= valid_d;
      dout_q       <= dout_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  assign valid      = valid_q;
  assign dout       = dout_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter
// Expected grant order follows ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_rom_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [22:0] addr0, addr1, addr2;
  logic [2:0]  valid;
  logic [15:0] dout;
  logic        sdram_req;
  logic [23:0] sdram_addr;
  logic        sdram_ack;
  logic [15:0] sdram_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  rom_arbiter #(
    .AW(23), .DW(16),
    .BASE0(24'h000000), .BASE1(24'h080000), .BASE2(24'hFFFFF0)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .valid(valid), .dout(dout),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .sdram_data(sdram_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for sdram_req, checks it, acks after lat cycles, checks completion.
  task automatic do_txn(input logic [23:0] exp_addr, input logic [2:0] exp_valid,
                        input logic [15:0] data, input int lat, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (sdram_req) found = 1'b1;
    end
    check(32'(found), 32'd1, {tag, "_req"});
    check(32'(busy), 32'd1, {tag, "_busy"});
    check(32'(sdram_addr), 32'(exp_addr), {tag, "_addr"});
    repeat (lat - 1) @(negedge clk);
    sdram_ack  = 1'b1;
    sdram_data = data;
    @(negedge clk);
    sdram_ack  = 1'b0;
    sdram_data = 16'h0000;
    check(32'(valid), 32'(exp_valid), {tag, "_valid"});
    check(32'(dout), 32'(data), {tag, "_dout"});
  endtask

  logic [23:0] c_addr [3];
  logic [2:0]  c_valid [3];
  logic        seen_req, seen_valid, found;

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    c_addr  = '{24'h080020, 24'h000020, 24'h000010};
    c_valid = '{3'b010, 3'b100, 3'b001};
`else
    c_addr  = '{24'h000010, 24'h080020, 24'h000020};
    c_valid = '{3'b001, 3'b010, 3'b100};
`endif
    reset = 1'b1; req = 3'b000; addr0 = '0; addr1 = '0; addr2 = '0;
    sdram_ack = 1'b0; sdram_data = 16'h0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check(32'(valid), 32'd0, "rst_valid");
    check(32'(dout), 32'd0, "rst_dout");
    check(32'(sdram_req), 32'd0, "rst_sdram_req");
    check(32'(sdram_addr), 32'd0, "rst_sdram_addr");
    check(32'(busy), 32'd0, "rst_busy");

    // Single request, held high after completion.
    addr0 = 23'h000123; req = 3'b001;
    do_txn(24'h000123, 3'b001, 16'hBEEF, 4, "single");
    seen_req = 1'b0; seen_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen_req   = seen_req | sdram_req;
      seen_valid = seen_valid | (|valid);
    end
    check(32'(seen_req), 32'd0, "single_no_reissue");
    check(32'(seen_valid), 32'd0, "single_valid_once");
    req = 3'b000;
    @(negedge clk);

    // Base offset with 24-bit wrap; ack lands in the ISSUE cycle.
    addr2 = 23'h000020; req = 3'b100;
    do_txn(24'h000010, 3'b100, 16'h5A5A, 1, "wrap");
    req = 3'b000;
    @(negedge clk);

    // Contention: client 0 abandons its first read, then re-requests.
    addr0 = 23'h000010; addr1 = 23'h000020; addr2 = 23'h000030; req = 3'b111;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (sdram_req) found = 1'b1;
    end
    check(32'(found), 32'd1, "cont0_req");
    check(32'(sdram_addr), 32'h000010, "cont0_addr");
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    sdram_ack = 1'b1; sdram_data = 16'h1111;
    @(negedge clk);
    sdram_ack = 1'b0; sdram_data = 16'h0000;
    check(32'(valid), 32'd0, "cont0_discard");
    check(32'(busy), 32'd0, "cont0_idle");
    req[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_txn(c_addr[i], c_valid[i], 16'hC000 + 16'(i), 2, $sformatf("cont%0d", i + 1));
    end
    req = 3'b000;
    @(negedge clk);

    // Abandoned request: client 1 drops during WAIT, client 2 then served.
    addr1 = 23'h000456; addr2 = 23'h000040; req = 3'b110;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (sdram_req) found = 1'b1;
    end
    check(32'(found), 32'd1, "aband_req");
    check(32'(sdram_addr), 32'h080456, "aband_addr");
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    sdram_ack = 1'b1; sdram_data = 16'h1234;
    @(negedge clk);
    sdram_ack = 1'b0; sdram_data = 16'h0000;
    check(32'(valid), 32'd0, "aband_no_valid");
    check(32'(busy), 32'd0, "aband_idle");
    do_txn(24'h000030, 3'b100, 16'h7777, 3, "aband_next");
    req = 3'b000;
    @(negedge clk);

    // Reset during WAIT, then a stale ack.
    addr0 = 23'h000007; req = 3'b001;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (sdram_req) found = 1'b1;
    end
    check(32'(found), 32'd1, "mrst_req");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check(32'(valid), 32'd0, "mrst_valid");
    check(32'(dout), 32'd0, "mrst_dout");
    check(32'(sdram_req), 32'd0, "mrst_sdram_req");
    check(32'(sdram_addr), 32'd0, "mrst_sdram_addr");
    check(32'(busy), 32'd0, "mrst_busy");
    req = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sdram_ack = 1'b1; sdram_data = 16'hFFFF;
    @(negedge clk);
    sdram_ack = 1'b0; sdram_data = 16'h0000;
    seen_req = 1'b0; seen_valid = |valid;
    repeat (4) begin
      @(negedge clk);
      seen_req   = seen_req | sdram_req;
      seen_valid = seen_valid | (|valid);
    end
    check(32'(seen_req), 32'd0, "stale_no_req");
    check(32'(seen_valid), 32'd0, "stale_no_valid");
    check(32'(dout), 32'd0, "stale_dout");
    addr1 = 23'h000001; req = 3'b010;
    do_txn(24'h080001, 3'b010, 16'hA5A5, 2, "post_rst");
    req = 3'b000;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
